// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU and its result buffer.
//   ALU_WIDTH   : default result width
//   *_BIT       : flag positions inside a packed entry, counted above the Y field
//   alu_entry_t : packed result entry {pos, neg, overflow, err, y} at ALU_WIDTH
package alu_pkg;
  localparam int ALU_WIDTH = 4;
  localparam int FLAG_W    = 4;
  localparam int ERR_BIT   = 0;
  localparam int OVF_BIT   = 1;
  localparam int NEG_BIT   = 2;
  localparam int POS_BIT   = 3;

  typedef struct packed {
    logic                 pos;
    logic                 neg;
    logic                 overflow;
    logic                 err;
    logic [ALU_WIDTH-1:0] y;
  } alu_entry_t;
endpackage

// File: rtl/alu_sat_counter.sv
// alu_sat_counter: saturating up-counter with synchronous clear.
//   i_CLK, i_RSTn : clock, async active-low reset
//   i_inc         : add one (holds at all-ones)
//   i_clr         : clear to zero, wins over i_inc
//   o_cnt         : current count
module alu_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                   cnt_d = '0;
    else if (i_inc && ~&cnt_q)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO between the ALU and its consumer. Captures {Y, err,
// overflow, neg, pos} on i_VALID/o_READY and presents the oldest entry on
// o_VALID/i_READY. One-cycle latency, no bypass.
//   i_CLK, i_RSTn          : clock, async active-low reset (drops all entries)
//   i_VALID/o_READY, i_Y, i_err/i_overflow/i_neg/i_pos : upstream side
//   o_VALID/i_READY, o_Y, o_err/o_overflow/o_neg/o_pos : consumer side
//   o_level                : occupancy 0..DEPTH
//   i_clr_stats, o_err_cnt, o_ovf_cnt : error/overflow statistics
// Macro ALU_RES_STATS_EN enables the statistics counters; without it the
// counter outputs are tied to 0 and i_clr_stats is ignored.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RSTn,
  input  logic                       i_VALID,
  output logic                       o_READY,
  input  logic [WIDTH-1:0]           i_Y,
  input  logic                       i_err,
  input  logic                       i_overflow,
  input  logic                       i_neg,
  input  logic                       i_pos,
  output logic                       o_VALID,
  input  logic                       i_READY,
  output logic [WIDTH-1:0]           o_Y,
  output logic                       o_err,
  output logic                       o_overflow,
  output logic                       o_neg,
  output logic                       o_pos,
  output logic [$clog2(DEPTH):0]     o_level,
  input  logic                       i_clr_stats,
  output logic [CNT_W-1:0]           o_err_cnt,
  output logic [CNT_W-1:0]           o_ovf_cnt
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENT_W  = WIDTH + FLAG_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push, pop;
  logic [ENT_W-1:0]  wr_ent, head;

  // Ready depends only on registered level, so no path from i_READY.
  assign o_READY = (level_q != FULL_LVL);
  assign o_VALID = (level_q != '0);
  assign push    = i_VALID & o_READY;
  assign pop     = o_VALID & i_READY;

  // Contradictory sign flags mark the result as erroneous.
  assign wr_ent = {i_pos, i_neg, i_overflow, i_err | (i_neg & i_pos), i_Y};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_ent;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Stale storage is masked so an empty buffer shows all-zero outputs.
  assign head       = o_VALID ? mem_q[rd_ptr_q] : '0;
  assign o_Y        = head[WIDTH-1:0];
  assign o_err      = head[WIDTH+ERR_BIT];
  assign o_overflow = head[WIDTH+OVF_BIT];
  assign o_neg      = head[WIDTH+NEG_BIT];
  assign o_pos      = head[WIDTH+POS_BIT];
  assign o_level    = level_q;

`ifdef ALU_RES_STATS_EN
  // Counted on the stored (sanitised) flags, not the raw inputs.
  alu_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .i_inc  (push & wr_ent[WIDTH+ERR_BIT]),
    .i_clr  (i_clr_stats),
    .o_cnt  (o_err_cnt)
  );
  alu_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .i_CLK  (i_CLK),
    .i_RSTn (i_RSTn),
    .i_inc  (push & wr_ent[WIDTH+OVF_BIT]),
    .i_clr  (i_clr_stats),
    .o_cnt  (o_ovf_cnt)
  );
`else
  logic unused_clr_stats;
  assign unused_clr_stats = i_clr_stats;
  assign o_err_cnt = '0;
  assign o_ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             i_CLK = 1'b0;
  logic             i_RSTn;
  logic             i_VALID, o_READY;
  logic [WIDTH-1:0] i_Y, o_Y;
  logic             i_err, i_overflow, i_neg, i_pos;
  logic             o_VALID, i_READY;
  logic             o_err, o_overflow, o_neg, o_pos;
  logic [2:0]       o_level;
  logic             i_clr_stats;
  logic [CNT_W-1:0] o_err_cnt, o_ovf_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb[$];
  int         m_err = 0;
  int         m_ovf = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn),
    .i_VALID(i_VALID), .o_READY(o_READY),
    .i_Y(i_Y), .i_err(i_err), .i_overflow(i_overflow), .i_neg(i_neg), .i_pos(i_pos),
    .o_VALID(o_VALID), .i_READY(i_READY),
    .o_Y(o_Y), .o_err(o_err), .o_overflow(o_overflow), .o_neg(o_neg), .o_pos(o_pos),
    .o_level(o_level), .i_clr_stats(i_clr_stats),
    .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int m);
`ifdef ALU_RES_STATS_EN
    return m;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor: compares the head against the model, then applies
  // the handshakes that will happen on the next rising edge.
  always @(negedge i_CLK) begin
    if (!i_RSTn) begin
      sb.delete();
      m_err = 0;
      m_ovf = 0;
      chk("rst_valid", 32'(o_VALID), 32'd0);
      chk("rst_level", 32'(o_level), 32'd0);
      chk("rst_y",     32'(o_Y),     32'd0);
      chk("rst_errcnt", 32'(o_err_cnt), 32'd0);
    end else begin
      int  sz;
      logic do_push, do_pop;
      logic [7:0] ent;
      sz = sb.size();
      chk("level", 32'(o_level), 32'(sz));
      chk("ready", 32'(o_READY), 32'(sz != DEPTH));
      chk("valid", 32'(o_VALID), 32'(sz != 0));
      chk("err_cnt", 32'(o_err_cnt), 32'(exp_cnt(m_err)));
      chk("ovf_cnt", 32'(o_ovf_cnt), 32'(exp_cnt(m_ovf)));
      if (sz != 0) chk("head", 32'({o_pos, o_neg, o_overflow, o_err, o_Y}), 32'(sb[0]));
      else         chk("empty_out", 32'({o_pos, o_neg, o_overflow, o_err, o_Y}), 32'd0);
      do_push = i_VALID && (sz != DEPTH);
      do_pop  = i_READY && (sz != 0);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        ent = {i_pos, i_neg, i_overflow, i_err | (i_neg & i_pos), i_Y};
        sb.push_back(ent);
      end
      if (i_clr_stats) begin
        m_err = 0;
        m_ovf = 0;
      end else if (do_push) begin
        if (ent[4] && m_err < CNT_MAX) m_err++;
        if (ent[5] && m_ovf < CNT_MAX) m_ovf++;
      end
    end
  end

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] y, input logic e,
                        input logic o, input logic n, input logic p);
    i_VALID = v; i_Y = y; i_err = e; i_overflow = o; i_neg = n; i_pos = p;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 12;
    i_VALID = 1'b0;
    i_READY = 1'b1;
    while (o_VALID && budget > 0) begin
      tick();
      budget--;
    end
    chk(tag, 32'(o_VALID), 32'd0);
    i_READY = 1'b0;
  endtask

  initial begin
    i_RSTn = 1'b0;
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_READY = 1'b0;
    i_clr_stats = 1'b0;
    repeat (2) tick();
    i_RSTn = 1'b1;
    tick();
    chk("init_ready", 32'(o_READY), 32'd1);

    // Single pass with a 5-cycle hold
    set_in(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    i_VALID = 1'b0;
    chk("sp_valid", 32'(o_VALID), 32'd1);
    chk("sp_y",     32'(o_Y), 32'hA);
    chk("sp_ovf",   32'(o_overflow), 32'd1);
    chk("sp_level", 32'(o_level), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sp_hold", 32'(o_Y), 32'hA);
    end
    i_READY = 1'b1;
    tick();
    i_READY = 1'b0;
    chk("sp_empty", 32'(o_VALID), 32'd0);
    chk("sp_y0",    32'(o_Y), 32'd0);

    // Fill to full, extra word refused, drain in order
    for (int v = 1; v <= 4; v++) begin
      set_in(1'b1, 4'(v), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("full_ready", 32'(o_READY), 32'd0);
    chk("full_level", 32'(o_level), 32'd4);
    i_VALID = 1'b0;
    i_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_order", 32'(o_Y), 32'(k + 1));
      tick();
    end
    i_READY = 1'b0;
    chk("fill_level0", 32'(o_level), 32'd0);

    // Concurrent push/pop at level 2 across pointer wrap
    set_in(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    i_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 4'(i + 3), 1'(i % 3 == 0), 1'(i % 2), 1'b0, 1'(i % 4 == 1));
      tick();
      chk("wrap_level", 32'(o_level), 32'd2);
    end
    drain("wrap_drain");

    // Reset with three entries held
    for (int v = 0; v < 3; v++) begin
      set_in(1'b1, 4'(v + 7), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    i_VALID = 1'b0;
    chk("pre_rst_level", 32'(o_level), 32'd3);
    i_RSTn = 1'b0;
    #1;
    chk("rst_async_valid", 32'(o_VALID), 32'd0);
    chk("rst_async_level", 32'(o_level), 32'd0);
    tick();
    i_RSTn = 1'b1;
    tick();
    chk("post_rst_ready", 32'(o_READY), 32'd1);
    chk("post_rst_level", 32'(o_level), 32'd0);

    // Flag sanitisation
    set_in(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    i_VALID = 1'b0;
    chk("san_err", 32'(o_err), 32'd1);
    chk("san_neg", 32'(o_neg), 32'd1);
    chk("san_pos", 32'(o_pos), 32'd1);
    drain("san_drain");

    // Statistics: saturation then clear-wins
    i_clr_stats = 1'b1;
    tick();
    i_clr_stats = 1'b0;
    i_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 4'(i), 1'b1, 1'(i < 2), 1'b0, 1'b0);
      tick();
    end
    i_VALID = 1'b0;
    tick();
`ifdef ALU_RES_STATS_EN
    chk("stat_err_sat", 32'(o_err_cnt), 32'd3);
    chk("stat_ovf",     32'(o_ovf_cnt), 32'd2);
`else
    chk("stat_err_off", 32'(o_err_cnt), 32'd0);
    chk("stat_ovf_off", 32'(o_ovf_cnt), 32'd0);
`endif
    set_in(1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
    i_clr_stats = 1'b1;
    tick();
    i_clr_stats = 1'b0;
    i_VALID = 1'b0;
    chk("stat_clr_err", 32'(o_err_cnt), 32'd0);
    chk("stat_clr_ovf", 32'(o_ovf_cnt), 32'd0);
    drain("stat_drain");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
